core_sleep_ctrl: RTL and testbench
==================================

# core_sleep_ctrl

Core sleep controller that generates the clock-enable for the core clock gate. It tracks WFI requests, outstanding data-bus transactions and Ascon-p accelerator activity, and drops the enable only when the core is fully quiescent. It restores the enable on interrupt or debug request. It runs on the free-running (ungated) clock and drives the clock gate's `en_i` directly.

## Interface
- `IDLE_CNT_W`, 4: width of the idle-hysteresis counter and of `idle_delay_i`.
- `OUTST_W`, 2: width of the outstanding-transaction counter.

- `clk_i`  in  1  free-running ungated clock
- `rst_ni`  in  1  reset, synchronous, active-low
- `fetch_en_i`  in  1  core boot enable (level)
- `wfi_req_i`  in  1  one-cycle pulse when the core retires WFI
- `irq_pending_i`  in  1  enabled interrupt pending (level, ungated domain)
- `debug_req_i`  in  1  debug halt request (level)
- `data_req_i`  in  1  data-bus request
- `data_gnt_i`  in  1  data-bus grant
- `data_rvalid_i`  in  1  data-bus response valid
- `accel_busy_i`  in  1  Ascon-p permutation in progress
- `idle_delay_i`  in  IDLE_CNT_W  hysteresis cycles before gating
- `core_clk_en_o`  out  1  enable to the clock gate
- `core_sleep_o`  out  1  core clock is off (BOOT or SLEEP)
- `wake_o`  out  1  one-cycle pulse on SLEEP→RUN
- `outstanding_o`  out  OUTST_W  current outstanding count

## Operation
- Wake condition: `wake = irq_pending_i | debug_req_i`.
- Quiet condition: `quiet = (outstanding == 0) & ~accel_busy_i & ~(data_req_i & data_gnt_i)`.
- Outstanding counter:
  - increments on `data_req_i & data_gnt_i`;
  - decrements on `data_rvalid_i`;
  - stays unchanged when both occur in the same cycle;
  - saturates at `2^OUTST_W-1` and holds at 0 on underflow;
  - counts in every state.
- FSM states:
  - **BOOT** (reset state): moves to RUN when `fetch_en_i`=1.
  - **RUN**: moves to DRAIN on `wfi_req_i & ~wake`. When `wfi_req_i & wake` occur together, stays in RUN, so WFI acts as a NOP.
  - **DRAIN**: `wake` → RUN (priority). Otherwise, when `quiet` holds, moves to HOLD (macro defined) or SLEEP (macro undefined).
  - **HOLD**: `wake` → RUN (priority). Otherwise `~quiet` → DRAIN. Otherwise, when the counter is 0, moves to SLEEP; if not 0, decrements. The counter loads `idle_delay_i` on entry to HOLD.
  - **SLEEP**: `wake` → RUN, with `wake_o`=1 for exactly one cycle.
- `core_clk_en_o` = 1 in RUN, DRAIN and HOLD; 0 in BOOT and SLEEP.
- `core_sleep_o` is the inverse of `core_clk_en_o`.
- Priority when events coincide: reset > wake > quiet/counter.

## Timing
- All outputs are registered and derived from the state register. There is no combinational path from any input to any output.
- Reset values: `core_clk_en_o`=0, `core_sleep_o`=1, `wake_o`=0, `outstanding_o`=0, state=BOOT, counter=0.
- Boot: `fetch_en_i` sampled high at edge N → `core_clk_en_o`=1 from N+1.
- Gating without the macro: `wfi_req_i` at edge N, with `quiet` true → DRAIN at N+1, SLEEP and `core_clk_en_o`=0 at N+2.
- Gating with the macro: HOLD adds `idle_delay_i`+1 cycles; `idle_delay_i`=0 gives SLEEP one cycle after entering HOLD.
- Wake: `wake` sampled at edge M while in SLEEP → `core_clk_en_o`=1 and `wake_o`=1 at M+1; `wake_o`=0 at M+2.
- `rst_ni` low at any edge, in any state, forces the reset values at that edge.

## Configuration
- `CORE_SLEEP_HYST_EN`
  - Defined: the HOLD state and idle counter exist; `idle_delay_i` is used.
  - Undefined: DRAIN goes directly to SLEEP, `idle_delay_i` is ignored, and no counter flops are synthesized.

## Test plan
- Reset with `fetch_en_i`=0 for 5 cycles → `core_clk_en_o`=0 and `core_sleep_o`=1 throughout. Then raise `fetch_en_i` → `core_clk_en_o`=1 one cycle later.
- Drain: 2 granted requests, then `wfi_req_i`, then rvalids 3 and 6 cycles later (macro off) → stays in DRAIN with enable high; SLEEP one cycle after the second rvalid.
- Accelerator: `accel_busy_i` high for 10 cycles after `wfi_req_i` → enable held high; enable drops 2 cycles after `accel_busy_i` falls (macro off).
- Hysteresis (macro on), `idle_delay_i`=3: quiet `wfi_req_i` at N → SLEEP at N+6. Repeat with `irq_pending_i` pulsed during HOLD → returns to RUN and never gates.
- Wake: in SLEEP, assert `irq_pending_i` at edge M → enable=1 and `wake_o`=1 at M+1; `wake_o`=0 at M+2. Separately, `wfi_req_i` and `irq_pending_i` in the same cycle → stays in RUN.
- Counter corners: with OUTST_W=2, 4 grants and no rvalid → saturates at 3. Simultaneous grant and rvalid → unchanged. Rvalid at 0 → stays 0. `rst_ni` low while in SLEEP → BOOT values at the next edge.

Source files
------------

// File: rtl/core_sleep_ctrl.sv
// core_sleep_ctrl: generates the core clock-gate enable from WFI, bus and accelerator activity.
// Optional idle hysteresis (HOLD state + idle counter) is enabled by defining CORE_SLEEP_HYST_EN.
module core_sleep_ctrl #(
    parameter int IDLE_CNT_W = 4,
    parameter int OUTST_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_en_i,
    input  logic                  wfi_req_i,
    input  logic                  irq_pending_i,
    input  logic                  debug_req_i,
    input  logic                  data_req_i,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic                  accel_busy_i,
    input  logic [IDLE_CNT_W-1:0] idle_delay_i,
    output logic                  core_clk_en_o,
    output logic                  core_sleep_o,
    output logic                  wake_o,
    output logic [OUTST_W-1:0]    outstanding_o
);
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_SLEEP = 3'd4
    } state_e;

    localparam logic [OUTST_W-1:0] OUTST_MAX  = {OUTST_W{1'b1}};
    localparam logic [OUTST_W-1:0] OUTST_ZERO = {OUTST_W{1'b0}};
    localparam logic [OUTST_W-1:0] OUTST_ONE  = OUTST_W'(1'b1);

    state_e             state_q, state_d;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               en_q, sleep_q, wake_q;
    logic               wake_s, quiet_s, issue_s, clk_on_d_s;

`ifdef CORE_SLEEP_HYST_EN
    localparam logic [IDLE_CNT_W-1:0] CNT_ZERO = {IDLE_CNT_W{1'b0}};
    localparam logic [IDLE_CNT_W-1:0] CNT_ONE  = IDLE_CNT_W'(1'b1);
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_idle_s;
    assign unused_idle_s = ^idle_delay_i;
`endif

    assign wake_s  = irq_pending_i | debug_req_i;
    assign issue_s = data_req_i & data_gnt_i;
    // A grant in the current cycle counts as activity even before the counter sees it.
    assign quiet_s = (outst_q == OUTST_ZERO) & ~accel_busy_i & ~issue_s;

    // Outstanding-transaction counter, saturating at max and holding at zero
    always_comb begin
        outst_d = outst_q;
        case ({issue_s, data_rvalid_i})
            2'b10: begin
                if (outst_q != OUTST_MAX) outst_d = outst_q + OUTST_ONE;
                else                      outst_d = outst_q;
            end
            2'b01: begin
                if (outst_q != OUTST_ZERO) outst_d = outst_q - OUTST_ONE;
                else                       outst_d = outst_q;
            end
            default: outst_d = outst_q;
        endcase
    end

    // Next-state logic; wake always takes priority over quiet/counter progress
    always_comb begin
        state_d = state_q;
`ifdef CORE_SLEEP_HYST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_BOOT: begin
                if (fetch_en_i) state_d = ST_RUN;
                else            state_d = ST_BOOT;
            end
            ST_RUN: begin
                if (wfi_req_i && !wake_s) state_d = ST_DRAIN;
                else                      state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (wake_s) begin
                    state_d = ST_RUN;
                end else if (quiet_s) begin
`ifdef CORE_SLEEP_HYST_EN
                    state_d = ST_HOLD;
                    cnt_d   = idle_delay_i;
`else
                    state_d = ST_SLEEP;
`endif
                end else begin
                    state_d = ST_DRAIN;
                end
            end
`ifdef CORE_SLEEP_HYST_EN
            ST_HOLD: begin
                if (wake_s)                state_d = ST_RUN;
                else if (!quiet_s)         state_d = ST_DRAIN;
                else if (cnt_q == CNT_ZERO) state_d = ST_SLEEP;
                else begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
`endif
            ST_SLEEP: begin
                if (wake_s) state_d = ST_RUN;
                else        state_d = ST_SLEEP;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign clk_on_d_s = (state_d == ST_RUN) | (state_d == ST_DRAIN) | (state_d == ST_HOLD);

    // State, counters and registered outputs; outputs track the state being entered
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            outst_q <= OUTST_ZERO;
            en_q    <= 1'b0;
            sleep_q <= 1'b1;
            wake_q  <= 1'b0;
`ifdef CORE_SLEEP_HYST_EN
            cnt_q   <= CNT_ZERO;
`endif
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            en_q    <= clk_on_d_s;
            sleep_q <= ~clk_on_d_s;
            wake_q  <= (state_q == ST_SLEEP) & wake_s;
`ifdef CORE_SLEEP_HYST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign core_clk_en_o = en_q;
    assign core_sleep_o  = sleep_q;
    assign wake_o        = wake_q;
    assign outstanding_o = outst_q;

endmodule

// File: tb/tb_core_sleep_ctrl.sv
// Directed scoreboard bench for core_sleep_ctrl; covers both CORE_SLEEP_HYST_EN builds.
module tb_core_sleep_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       fetch_en_i, wfi_req_i, irq_pending_i, debug_req_i;
    logic       data_req_i, data_gnt_i, data_rvalid_i, accel_busy_i;
    logic [3:0] idle_delay_i;
    logic       core_clk_en_o, core_sleep_o, wake_o;
    logic [1:0] outstanding_o;

    logic [4:0] exp_q[$];
    string      tag_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    core_sleep_ctrl #(.IDLE_CNT_W(4), .OUTST_W(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .fetch_en_i    (fetch_en_i),
        .wfi_req_i     (wfi_req_i),
        .irq_pending_i (irq_pending_i),
        .debug_req_i   (debug_req_i),
        .data_req_i    (data_req_i),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .accel_busy_i  (accel_busy_i),
        .idle_delay_i  (idle_delay_i),
        .core_clk_en_o (core_clk_en_o),
        .core_sleep_o  (core_sleep_o),
        .wake_o        (wake_o),
        .outstanding_o (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    // Push the outputs expected after the coming edge, step one clock, then pop and compare.
    task automatic cyc(input string tag, input logic en, input logic wk, input logic [1:0] outst);
        logic [4:0] exp_v, obs_v;
        string      t;
        exp_q.push_back({en, ~en, wk, outst});
        tag_q.push_back(tag);
        @(posedge clk_i);
        #1;
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {core_clk_en_o, core_sleep_o, wake_o, outstanding_o};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed en/slp/wake/outst=%b expected=%b", t, obs_v, exp_v);
        end
    endtask

    task automatic cycn(input int n, input string tag, input logic en, input logic [1:0] outst);
        for (int i = 0; i < n; i++) cyc(tag, en, 1'b0, outst);
    endtask

    initial begin
        rst_ni = 1'b0; fetch_en_i = 1'b0; wfi_req_i = 1'b0; irq_pending_i = 1'b0;
        debug_req_i = 1'b0; data_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        accel_busy_i = 1'b0; idle_delay_i = 4'd0;

        // Reset and boot
        cycn(5, "reset", 1'b0, 2'd0);
        rst_ni = 1'b1;
        cycn(2, "boot_wait", 1'b0, 2'd0);
        fetch_en_i = 1'b1;
        cyc("boot_run", 1'b1, 1'b0, 2'd0);

        // Drain: two grants, WFI, rvalids 3 and 6 cycles after WFI
        data_req_i = 1'b1; data_gnt_i = 1'b1;
        cyc("grant1", 1'b1, 1'b0, 2'd1);
        cyc("grant2", 1'b1, 1'b0, 2'd2);
        data_req_i = 1'b0; data_gnt_i = 1'b0; wfi_req_i = 1'b1;
        cyc("drain_wfi", 1'b1, 1'b0, 2'd2);
        wfi_req_i = 1'b0;
        cycn(2, "drain_wait", 1'b1, 2'd2);
        data_rvalid_i = 1'b1;
        cyc("drain_rv1", 1'b1, 1'b0, 2'd1);
        data_rvalid_i = 1'b0;
        cycn(2, "drain_wait2", 1'b1, 2'd1);
        data_rvalid_i = 1'b1;
        cyc("drain_rv2", 1'b1, 1'b0, 2'd0);
        data_rvalid_i = 1'b0;
`ifdef CORE_SLEEP_HYST_EN
        cyc("drain_hold", 1'b1, 1'b0, 2'd0);
`endif
        cyc("drain_sleep", 1'b0, 1'b0, 2'd0);
        cyc("sleep_stay", 1'b0, 1'b0, 2'd0);

        // Wake from SLEEP on interrupt
        irq_pending_i = 1'b1;
        cyc("irq_wake", 1'b1, 1'b1, 2'd0);
        irq_pending_i = 1'b0;
        cyc("wake_pulse_end", 1'b1, 1'b0, 2'd0);

        // WFI coincident with wake is a NOP
        wfi_req_i = 1'b1; irq_pending_i = 1'b1;
        cyc("wfi_irq", 1'b1, 1'b0, 2'd0);
        wfi_req_i = 1'b0; irq_pending_i = 1'b0;
        cycn(3, "wfi_nop", 1'b1, 2'd0);

        // Accelerator busy keeps the clock running
        accel_busy_i = 1'b1; wfi_req_i = 1'b1;
        cyc("accel_wfi", 1'b1, 1'b0, 2'd0);
        wfi_req_i = 1'b0;
        cycn(10, "accel_busy", 1'b1, 2'd0);
        accel_busy_i = 1'b0;
`ifdef CORE_SLEEP_HYST_EN
        cyc("accel_hold", 1'b1, 1'b0, 2'd0);
`endif
        cyc("accel_sleep", 1'b0, 1'b0, 2'd0);
        debug_req_i = 1'b1;
        cyc("dbg_wake", 1'b1, 1'b1, 2'd0);
        debug_req_i = 1'b0;
        cyc("dbg_wake_end", 1'b1, 1'b0, 2'd0);

`ifdef CORE_SLEEP_HYST_EN
        // Hysteresis with idle_delay 3: SLEEP five edges after the WFI edge
        idle_delay_i = 4'd3; wfi_req_i = 1'b1;
        cyc("hyst_wfi", 1'b1, 1'b0, 2'd0);
        wfi_req_i = 1'b0;
        cycn(4, "hyst_hold", 1'b1, 2'd0);
        cyc("hyst_sleep", 1'b0, 1'b0, 2'd0);
        irq_pending_i = 1'b1;
        cyc("hyst_wake", 1'b1, 1'b1, 2'd0);
        irq_pending_i = 1'b0;
        cyc("hyst_wake_end", 1'b1, 1'b0, 2'd0);
        // Interrupt during HOLD aborts gating
        wfi_req_i = 1'b1;
        cyc("hyst2_wfi", 1'b1, 1'b0, 2'd0);
        wfi_req_i = 1'b0;
        cyc("hyst2_hold", 1'b1, 1'b0, 2'd0);
        irq_pending_i = 1'b1;
        cyc("hyst2_irq", 1'b1, 1'b0, 2'd0);
        irq_pending_i = 1'b0;
        cycn(8, "hyst2_run", 1'b1, 2'd0);
        idle_delay_i = 4'd0;
`endif

        // Counter corners: saturation, simultaneous grant/rvalid, underflow
        data_req_i = 1'b1; data_gnt_i = 1'b1;
        cyc("sat1", 1'b1, 1'b0, 2'd1);
        cyc("sat2", 1'b1, 1'b0, 2'd2);
        cyc("sat3", 1'b1, 1'b0, 2'd3);
        cyc("sat4", 1'b1, 1'b0, 2'd3);
        data_rvalid_i = 1'b1;
        cyc("gnt_rv", 1'b1, 1'b0, 2'd3);
        data_req_i = 1'b0; data_gnt_i = 1'b0;
        cyc("dec2", 1'b1, 1'b0, 2'd2);
        cyc("dec1", 1'b1, 1'b0, 2'd1);
        cyc("dec0", 1'b1, 1'b0, 2'd0);
        cyc("underflow", 1'b1, 1'b0, 2'd0);
        data_rvalid_i = 1'b0;
        data_req_i = 1'b1;
        cyc("req_no_gnt", 1'b1, 1'b0, 2'd0);
        data_req_i = 1'b0;

        // Reset while sleeping, with a wake request on the same edge
        wfi_req_i = 1'b1;
        cyc("rst_wfi", 1'b1, 1'b0, 2'd0);
        wfi_req_i = 1'b0;
`ifdef CORE_SLEEP_HYST_EN
        cyc("rst_hold", 1'b1, 1'b0, 2'd0);
`endif
        cyc("rst_sleep", 1'b0, 1'b0, 2'd0);
        data_req_i = 1'b1; data_gnt_i = 1'b1;
        cyc("sleep_count", 1'b0, 1'b0, 2'd1);
        data_req_i = 1'b0; data_gnt_i = 1'b0;
        rst_ni = 1'b0; irq_pending_i = 1'b1;
        cyc("rst_in_sleep", 1'b0, 1'b0, 2'd0);
        rst_ni = 1'b1; irq_pending_i = 1'b0; fetch_en_i = 1'b0;
        cyc("rst_boot", 1'b0, 1'b0, 2'd0);
        fetch_en_i = 1'b1;
        cyc("reboot", 1'b1, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
